// File: rtl/dist_delay_tree.sv
// Pairwise AND/OR/XOR reduction tree. Each level's result runs through its own
// delay line, and the per-level delays can be reloaded whenever the tree is empty.
module dist_delay_tree #(
  parameter int WIDTH     = 1,
  parameter int LEAVES    = 4,
  parameter int DW        = 3,
  parameter int RST_DELAY = 1
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               in_valid,
  input  logic [LEAVES*WIDTH-1:0]            in_data,
  input  logic [1:0]                         op,
  input  logic                               cfg_load,
  input  logic [$clog2(LEAVES)*DW-1:0]       cfg_delay,
  output logic                               out_valid,
  output logic [WIDTH-1:0]                   out_data,
  output logic                               busy,
  output logic                               cfg_ack,
  output logic                               drop,
  output logic [$clog2(LEAVES)*DW:0]         latency
);

  localparam int LEVELS = $clog2(LEAVES);
  localparam int MAXD   = 2**DW - 1;
  localparam int LW     = LEVELS*DW + 1;

  logic [DW-1:0]     dly [LEVELS];
  logic [LEVELS-1:0] lvl_busy;
  logic              accept;
  logic              v0;
  logic [LW-1:0]     lat_next;
  logic [WIDTH-1:0]  held;

  // A load may only land on an empty tree, so no sample ever straddles two delay sets.
  assign accept = cfg_load & ~busy;
  assign v0     = in_valid & reset & ~accept;
  assign busy   = |lvl_busy;

  always_comb begin
    lat_next = '0;
    for (int k = 0; k < LEVELS; k++)
      lat_next = lat_next + LW'(cfg_delay[k*DW +: DW]);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int k = 0; k < LEVELS; k++) dly[k] <= DW'(RST_DELAY);
      latency <= LW'(LEVELS*RST_DELAY);
      cfg_ack <= 1'b0;
      drop    <= 1'b0;
    end else begin
      cfg_ack <= accept;
      drop    <= accept & in_valid;
      if (accept) begin
        for (int k = 0; k < LEVELS; k++) dly[k] <= cfg_delay[k*DW +: DW];
        latency <= lat_next;
      end
    end
  end

  genvar k;
  for (k = 0; k < LEVELS; k++) begin : lvl
    localparam int N = LEAVES >> (k+1);

    logic [2*N*WIDTH-1:0] din;
    logic                 din_v;
    logic [1:0]           din_op;
    logic [N*WIDTH-1:0]   res;
    logic [N*WIDTH-1:0]   sd [MAXD];
    logic [MAXD-1:0]      sv;
    logic                 tv;
    logic [N*WIDTH-1:0]   td;

    if (k == 0) begin : g_src
      assign din    = in_data;
      assign din_v  = v0;
      assign din_op = op;
    end else begin : g_chain
      assign din    = lvl[k-1].td;
      assign din_v  = lvl[k-1].tv;
      assign din_op = lvl[k-1].g_op.top;
    end

    always_comb begin
      res = '0;
      for (int j = 0; j < N; j++) begin
        case (din_op)
          2'b01:   res[j*WIDTH +: WIDTH] = din[2*j*WIDTH +: WIDTH] | din[(2*j+1)*WIDTH +: WIDTH];
          2'b10:   res[j*WIDTH +: WIDTH] = din[2*j*WIDTH +: WIDTH] ^ din[(2*j+1)*WIDTH +: WIDTH];
          default: res[j*WIDTH +: WIDTH] = din[2*j*WIDTH +: WIDTH] & din[(2*j+1)*WIDTH +: WIDTH];
        endcase
      end
    end

    // Valid bits die past the tap, so a later, longer delay cannot resurrect stale samples.
    always_ff @(posedge clock) begin
      if (!reset) begin
        sv <= '0;
        for (int i = 0; i < MAXD; i++) sd[i] <= '0;
      end else begin
        sv[0] <= din_v && (dly[k] != '0);
        sd[0] <= res;
        for (int i = 1; i < MAXD; i++) begin
          sv[i] <= sv[i-1] && (DW'(i) < dly[k]);
          sd[i] <= sd[i-1];
        end
      end
    end

    always_comb begin
      if (dly[k] == '0) begin
        tv = din_v;
        td = res;
      end else begin
        tv = sv[dly[k] - DW'(1)];
        td = sd[dly[k] - DW'(1)];
      end
    end

    assign lvl_busy[k] = |sv;

    // The last level has no consumer for op, so only inner levels carry it.
    if (k < LEVELS-1) begin : g_op
      logic [1:0] sop [MAXD];
      logic [1:0] top;

      always_ff @(posedge clock) begin
        if (!reset) begin
          for (int i = 0; i < MAXD; i++) sop[i] <= '0;
        end else begin
          sop[0] <= din_op;
          for (int i = 1; i < MAXD; i++) sop[i] <= sop[i-1];
        end
      end

      assign top = (dly[k] == '0) ? din_op : sop[dly[k] - DW'(1)];
    end
  end

  assign out_valid = lvl[LEVELS-1].tv & reset;
  assign out_data  = out_valid ? lvl[LEVELS-1].td : held;

  always_ff @(posedge clock) begin
    if (!reset)        held <= '0;
    else if (out_valid) held <= lvl[LEVELS-1].td;
  end

endmodule
